// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a framed, big-endian byte
// stream (count[15:8], count[7:0], then count words MSB byte first), issuing
// one word write per assembled word and holding the core in reset via busy.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.

module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        WE,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK  = 3'd6
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_hi_q, cnt_hi_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;
  logic        we_q, we_d;
  logic [31:0] a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] words_q, words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  logic accept;

  // Stream readiness is a pure function of the state.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_CNT_HI, S_CNT_LO, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                      in_ready = 1'b1;
`endif
      default:                    in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Next-state, word assembly and write-port decisions.
  always_comb begin
    state_d    = state_q;
    cnt_hi_d   = cnt_hi_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    a_d        = a_q;
    wd_d       = wd_q;
    words_d    = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_CNT_HI;
          a_d        = BASE_ADDR;
          words_d    = 16'd0;
          byte_idx_d = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = 8'd0;
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_CNT_HI: begin
        if (accept) begin
          cnt_hi_d = in_data;
          state_d  = S_CNT_LO;
        end
      end

      S_CNT_LO: begin
        if (accept) begin
          count_d = {cnt_hi_q, in_data};
          if (32'(count_d) > DEPTH) begin
            state_d = S_ERR;
          end else if (count_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ in_data;
`endif
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            wd_d    = {asm_q, in_data};
            a_d     = BASE_ADDR + (32'(words_q) << 2);
            words_d = words_q + 16'd1;
            if (words_d == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end
          end else begin
            asm_d = {asm_q[15:0], in_data};
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (in_data == chk_q) ? S_DONE : S_ERR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    busy_d = busy_d || (state_d == S_CHK);
`endif
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_hi_q   <= 8'd0;
      count_q    <= 16'd0;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'd0;
      we_q       <= 1'b0;
      a_q        <= BASE_ADDR;
      wd_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      a_q        <= a_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      words_q    <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign WE           = we_q;
  assign A            = a_q;
  assign WD           = wd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule
